axis_bram_reader: RTL
=====================

Name: axis_bram_reader

Overview:
- AXI-Stream master that reads a contiguous block of words from a BRAM port and streams them out, with TLAST on the final word.
- Mirrors the stream-to-buffer adapter on the transmit side. Software or the control FSM loads BASE_ADDR and LEN and pulses START; the block issues 1-cycle-latency BRAM reads and absorbs downstream backpressure in a 2-entry output FIFO.
- Sustains 1 beat/cycle while TREADY is held high.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32: stream and BRAM data width. Must be a multiple of 8.
- C_ADDR_WIDTH, 10: BRAM word-address width.

Ports:
- M_AXIS_ACLK  in  1  clock; all logic on rising edge.
- M_AXIS_ARESET  in  1  synchronous, active-high reset.
- START  in  1  single-cycle start request. Sampled only in IDLE.
- BASE_ADDR  in  C_ADDR_WIDTH  first word address. Latched on an accepted START.
- LEN  in  C_ADDR_WIDTH+1  word count, 1..2^C_ADDR_WIDTH. Latched on an accepted START.
- BUSY  out  1  high from an accepted START until the last beat handshakes.
- DONE  out  1  one-cycle pulse on the cycle after the last beat handshakes.
- BRAM_EN  out  1  read enable.
- BRAM_ADDR  out  C_ADDR_WIDTH  read address.
- BRAM_DOUT  in  C_M_AXIS_TDATA_WIDTH  read data, valid the cycle after BRAM_EN.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte qualifier. Constant all-ones.
- M_AXIS_TLAST  out  1  marks the final word.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset values:
  - State = IDLE; BUSY, DONE, BRAM_EN, M_AXIS_TVALID and M_AXIS_TLAST are 0.
  - BRAM_ADDR = 0, M_AXIS_TDATA = 0.
  - FIFO emptied; issue/beat counters and in-flight flag cleared.
- States:
  - IDLE: START=1 with LEN!=0 latches BASE_ADDR/LEN and moves to RUN. START with LEN=0 is ignored: stay in IDLE, no DONE.
  - RUN: issue reads and drain the FIFO. On the handshake of the beat with TLAST, go to IDLE; DONE=1 and BUSY=0 on the next cycle.
  - START in RUN is ignored.
- Read issue:
  - pop = TVALID && TREADY.
  - issue = RUN && reads_remaining!=0 && (fifo_count + inflight - pop) < 2.
  - BRAM_EN = issue (combinational from registered state is acceptable; BRAM_ADDR must be registered).
  - Address starts at BASE_ADDR and increments by 1 per issue, wrapping modulo 2^C_ADDR_WIDTH.
  - inflight is set on issue; BRAM_DOUT is pushed into the FIFO the following cycle.
  - FIFO never exceeds 2 entries; push and pop in the same cycle are allowed.
- Latency: START accepted at edge N → BRAM_EN=1, BRAM_ADDR=BASE during cycle N+1 → BRAM_DOUT captured at end of N+2 → TVALID=1 with word 0 in cycle N+3.
- AXIS rules:
  - TVALID does not wait for TREADY.
  - Once TVALID=1, it stays high and TDATA/TLAST stay stable until the handshake.
  - TVALID follows FIFO non-empty.
- TLAST: high exactly on beat LEN-1, counted by a beat counter on pops, not by address.
- Backpressure: with TREADY low, reads stop after the FIFO and in-flight slot hold 2 words. Reads resume on pop with no data lost or duplicated.
- Full length: LEN=2^C_ADDR_WIDTH reads every address exactly once, starting at BASE and wrapping.
- Reset mid-transfer: next cycle TVALID=0, BRAM_EN=0, BUSY=0 and DONE=0; the in-flight word is discarded; no TLAST is emitted.

Test Plan:
- Basic read, TREADY=1 constant: BRAM[i]=0x1000+i, BASE=5, LEN=4, START → first TVALID 3 cycles after START. TDATA 0x1005..0x1008 on consecutive cycles, TLAST on 0x1008, DONE one cycle later, BUSY low.
- Backpressure: LEN=8, TREADY toggled in a 1-0-0-1 pattern → all 8 words in order, no duplicates or drops. BRAM_EN never raises occupancy above 2; TDATA stable while stalled.
- Wrap: C_ADDR_WIDTH=10, BASE=1022, LEN=4 → BRAM_ADDR sequence 1022, 1023, 0, 1. TLAST on the 4th beat.
- Edge lengths: LEN=1 → single beat with TLAST=1 and a DONE pulse. LEN=0 → no BRAM_EN, no TVALID, no DONE. LEN=1024 with BASE=0 → 1024 beats, full throughput.
- START while BUSY: a second START mid-transfer with different BASE/LEN → ignored; the original transfer completes unchanged.
- Reset mid-transfer: assert M_AXIS_ARESET after the 3rd beat of LEN=8 → outputs at reset values next cycle. A subsequent START with BASE=0, LEN=2 runs cleanly.

Source files
------------

// File: rtl/axis_bram_reader.sv
// Purpose : AXI-Stream master that streams LEN words read from a BRAM port, starting
//           at BASE_ADDR and wrapping modulo the address space. TLAST marks the final word.
// Latency : START accepted at edge N -> BRAM read in cycle N+1 -> first beat valid in
//           cycle N+3. Sustains one beat per cycle while M_AXIS_TREADY stays high.
// Backpr. : a 2-entry output FIFO absorbs stalls. Reads stop once FIFO plus in-flight
//           read hold 2 words, and resume on the next pop. No word is lost or duplicated.
// Ports   : M_AXIS_ACLK/M_AXIS_ARESET are the clock and the synchronous active-high reset.
//           START/BASE_ADDR/LEN are the control inputs. BUSY/DONE report status.
//           BRAM_EN/BRAM_ADDR/BRAM_DOUT form the read port (1-cycle latency).
//           M_AXIS_T* is the master stream.
module axis_bram_reader #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH         = 10
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESET,
  input  logic                                START,
  input  logic [C_ADDR_WIDTH-1:0]             BASE_ADDR,
  input  logic [C_ADDR_WIDTH:0]               LEN,
  output logic                                BUSY,
  output logic                                DONE,
  output logic                                BRAM_EN,
  output logic [C_ADDR_WIDTH-1:0]             BRAM_ADDR,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     BRAM_DOUT,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  input  logic                                M_AXIS_TREADY
);

  localparam int CW = C_ADDR_WIDTH + 1;
  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam logic [CW-1:0]           CNT_ONE  = CW'(1);
  localparam logic [C_ADDR_WIDTH-1:0] ADDR_ONE = C_ADDR_WIDTH'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [C_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]           reads_rem_q, reads_rem_d;
  logic [CW-1:0]           len_q, len_d;
  logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              count_q, count_d;
  logic [DW-1:0]           head_q, head_d;
  logic [DW-1:0]           tail_q, tail_d;
  logic                    done_q, done_d;

  logic       fifo_vld;
  logic       pop;
  logic       push;
  logic       issue;
  logic       start_ok;
  logic       last_beat;
  logic [2:0] occ;

  // Handshake and issue qualification shared by next-state and output logic.
  always_comb begin
    fifo_vld  = (count_q != 2'd0);
    pop       = fifo_vld && M_AXIS_TREADY;
    // The read issued last cycle returns its data now.
    push      = inflight_q;
    // Beat index, not address, decides TLAST so that wrapping cannot confuse it.
    last_beat = (beat_cnt_q == (len_q - CNT_ONE));
    // Words already owned by the block after this cycle's pop. A new read is allowed
    // only if its word still fits in the 2-entry FIFO.
    occ       = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == RUN) && (reads_rem_q != '0) && (occ < 3'd2);
    start_ok  = (state_q == IDLE) && START && (LEN != '0);
  end

  // State register
  always_ff @(posedge M_AXIS_ACLK) begin
    if (M_AXIS_ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      reads_rem_q <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      reads_rem_q <= reads_rem_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      inflight_q  <= inflight_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    reads_rem_d = reads_rem_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    inflight_d  = issue;
    done_d      = 1'b0;
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = RUN;
          addr_d      = BASE_ADDR;
          reads_rem_d = LEN;
          len_d       = LEN;
          beat_cnt_d  = '0;
        end
      end
      RUN: begin
        if (issue) begin
          // Address wraps naturally at the BRAM size.
          addr_d      = addr_q + ADDR_ONE;
          reads_rem_d = reads_rem_q - CNT_ONE;
        end
        if (pop) begin
          if (last_beat) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Two-entry FIFO: head drives the stream, tail holds the word behind it.
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = BRAM_DOUT;
        end else begin
          tail_d = BRAM_DOUT;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = BRAM_DOUT;
        end else begin
          head_d = tail_q;
          tail_d = BRAM_DOUT;
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    BUSY          = (state_q == RUN);
    DONE          = done_q;
    BRAM_EN       = issue;
    BRAM_ADDR     = addr_q;
    M_AXIS_TVALID = fifo_vld;
    M_AXIS_TDATA  = head_q;
    M_AXIS_TLAST  = fifo_vld && last_beat;
    M_AXIS_TSTRB  = '1;
  end

endmodule
